key_unlock_seq: RTL and testbench

Bus-master sequencer that performs the key-read handshake against the registered security decoder in the BA13:BA12 = 01 window. On a start pulse it requests the shared address bus, issues SEQ_LEN selected read cycles (SSER low, BR_W high) with a programmed nibble on BA7:BA4, and samples the SDRD response bit of each cycle against an expected bit. It reports pass, or the first failing step, back to the host. It sits between the host control logic and the decoder, and shares the bus with the CPU through a request/grant pair.

---
 rtl/key_unlock_pkg.sv | 20 ++
 rtl/key_unlock_seq_if.sv | 28 ++
 rtl/key_unlock_step_ctr.sv | 53 +++++
 rtl/key_unlock_seq.sv | 153 +++++++++++++++
 tb/tb_key_unlock_seq.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/key_unlock_pkg.sv
// Shared types and helpers for the key-read unlock sequencer.
package key_unlock_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_ADDR,
      ST_SAMPLE,
      ST_GAP,
      ST_DONE
   } state_e;

   localparam logic [1:0] DEC_WINDOW_HI = 2'b01;

   // Selected read address: window bits on BA13:BA12, key nibble on BA7:BA4.
   function automatic logic [13:0] compose_ba(input logic [1:0] hi, input logic [3:0] nib);
      return {hi, 4'h0, nib, 4'h0};
   endfunction

endpackage

// File: rtl/key_unlock_seq_if.sv
// Decoder/arbiter side of the sequencer: bus request/grant plus the select bus.
// Handshake: bus_req stays high until the sequence ends; the bus is ours only while bus_gnt is high.
interface key_unlock_seq_if;
   logic        bus_req;
   logic        bus_gnt;
   logic [13:0] ba;
   logic        sser;
   logic        br_w;
   logic        sdrd;

   modport master (
      output bus_req,
      output ba,
      output sser,
      output br_w,
      input  bus_gnt,
      input  sdrd
   );

   modport slave (
      input  bus_req,
      input  ba,
      input  sser,
      input  br_w,
      output bus_gnt,
      output sdrd
   );
endinterface

// File: rtl/key_unlock_step_ctr.sv
// Settle counter for the ADDR phase and the step index of the key sequence.
module key_unlock_step_ctr #(
   parameter int SEQ_LEN    = 8,
   parameter int SETTLE_CYC = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic       settle_en_i,
   input  logic       step_en_i,
   output logic       settle_last_o,
   output logic       step_last_o,
   output logic [3:0] idx_o
);

   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYC - 1);
   localparam logic [3:0]    IDX_MAX    = 4'(SEQ_LEN - 1);

   logic [SW-1:0] settle_q, settle_d;
   logic [3:0]    idx_q, idx_d;

   assign settle_last_o = (settle_q == SETTLE_MAX);
   assign step_last_o   = (idx_q == IDX_MAX);
   assign idx_o         = idx_q;

   // The settle counter wraps on its last cycle so every ADDR phase starts from zero.
   always_comb begin
      settle_d = settle_q;
      idx_d    = idx_q;
      if (load_i) begin
         settle_d = '0;
         idx_d    = '0;
      end else begin
         if (settle_en_i) settle_d = settle_last_o ? '0 : settle_q + 1'b1;
         if (step_en_i) begin
            idx_d    = idx_q + 4'd1;
            settle_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         settle_q <= '0;
         idx_q    <= '0;
      end else begin
         settle_q <= settle_d;
         idx_q    <= idx_d;
      end
   end

endmodule

// File: rtl/key_unlock_seq.sv
// Bus-master sequencer: requests the bus, runs SEQ_LEN selected key reads and
// checks each SDRD response, reporting pass / first failing step / grant loss.
module key_unlock_seq
   import key_unlock_pkg::*;
#(
   parameter int         SEQ_LEN    = 8,
   parameter int         SETTLE_CYC = 2,
   parameter logic [1:0] ADDR_HI    = DEC_WINDOW_HI
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic [4*SEQ_LEN-1:0]   key_nib_i,
   input  logic [SEQ_LEN-1:0]     expect_bits_i,
   key_unlock_seq_if.master       bus,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   pass_o,
   output logic                   aborted_o,
   output logic [3:0]             fail_step_o,
   output state_e                 state_o
);

   state_e      state_q;
   logic        bus_req_q, sser_q, busy_q, done_q, pass_q, aborted_q;
   logic [13:0] ba_q;
   logic [3:0]  fail_step_q;
   logic [63:0] key_q;
   logic [15:0] exp_q;

   logic       load, settle_en, step_en;
   logic       settle_last, step_last;
   logic [3:0] idx;
   logic [3:0] nib_cur, nib_next;
   logic       on_bus;

   assign on_bus    = (state_q == ST_ADDR) || (state_q == ST_SAMPLE) || (state_q == ST_GAP);
   assign load      = (state_q == ST_IDLE) && start_i;
   assign settle_en = (state_q == ST_ADDR) && bus.bus_gnt;
   assign step_en   = (state_q == ST_GAP) && bus.bus_gnt && !step_last;
   assign nib_cur   = key_q[{idx, 2'b00} +: 4];
   assign nib_next  = key_q[{idx + 4'd1, 2'b00} +: 4];

   key_unlock_step_ctr #(
      .SEQ_LEN    (SEQ_LEN),
      .SETTLE_CYC (SETTLE_CYC)
   ) u_ctr (
      .clk           (clk),
      .rst           (rst),
      .load_i        (load),
      .settle_en_i   (settle_en),
      .step_en_i     (step_en),
      .settle_last_o (settle_last),
      .step_last_o   (step_last),
      .idx_o         (idx)
   );

   // Outputs are registered; only a lost grant releases sser without waiting a clock.
   assign bus.sser    = sser_q | ~bus.bus_gnt;
   assign bus.bus_req = bus_req_q;
   assign bus.ba      = ba_q;
   assign bus.br_w    = 1'b1;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign pass_o      = pass_q;
   assign aborted_o   = aborted_q;
   assign fail_step_o = fail_step_q;
   assign state_o     = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bus_req_q   <= 1'b0;
         sser_q      <= 1'b1;
         ba_q        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         aborted_q   <= 1'b0;
         fail_step_q <= '0;
         key_q       <= '0;
         exp_q       <= '0;
      end else begin
         done_q <= 1'b0;
         if (on_bus && !bus.bus_gnt) begin
            state_q     <= ST_DONE;
            aborted_q   <= 1'b1;
            pass_q      <= 1'b0;
            fail_step_q <= idx;
            bus_req_q   <= 1'b0;
            sser_q      <= 1'b1;
            ba_q        <= '0;
            done_q      <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start_i) begin
                     key_q       <= 64'(key_nib_i);
                     exp_q       <= 16'(expect_bits_i);
                     pass_q      <= 1'b0;
                     aborted_q   <= 1'b0;
                     fail_step_q <= '0;
                     bus_req_q   <= 1'b1;
                     busy_q      <= 1'b1;
                     state_q     <= ST_REQ;
                  end
               end
               ST_REQ: begin
                  if (bus.bus_gnt) begin
                     sser_q  <= 1'b0;
                     ba_q    <= compose_ba(ADDR_HI, nib_cur);
                     state_q <= ST_ADDR;
                  end
               end
               ST_ADDR: begin
                  if (settle_last) state_q <= ST_SAMPLE;
               end
               ST_SAMPLE: begin
                  sser_q <= 1'b1;
                  ba_q   <= '0;
                  if (bus.sdrd != exp_q[idx]) begin
                     fail_step_q <= idx;
                     pass_q      <= 1'b0;
                     bus_req_q   <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= ST_DONE;
                  end else begin
                     state_q <= ST_GAP;
                  end
               end
               ST_GAP: begin
                  if (step_last) begin
                     pass_q    <= 1'b1;
                     bus_req_q <= 1'b0;
                     done_q    <= 1'b1;
                     state_q   <= ST_DONE;
                  end else begin
                     sser_q  <= 1'b0;
                     ba_q    <= compose_ba(ADDR_HI, nib_next);
                     state_q <= ST_ADDR;
                  end
               end
               ST_DONE: begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_key_unlock_seq.sv
// Directed bench for key_unlock_seq: pass, mismatch, delayed grant, grant loss,
// mid-sequence reset and ignored start pulses.
module tb_key_unlock_seq;
   import key_unlock_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic [31:0] key_nib_i = 32'h8765_4321;
   logic [7:0]  expect_bits_i = 8'hA5;
   logic        busy_o, done_o, pass_o, aborted_o;
   logic [3:0]  fail_step_o;
   state_e      state_o;

   key_unlock_seq_if bus ();

   key_unlock_seq dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .key_nib_i     (key_nib_i),
      .expect_bits_i (expect_bits_i),
      .bus           (bus),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .pass_o        (pass_o),
      .aborted_o     (aborted_o),
      .fail_step_o   (fail_step_o),
      .state_o       (state_o)
   );

   always #5 clk = ~clk;

   // Decoder model: key nibble k+1 selects step k; answers the expected bit unless flipped.
   logic [15:0] model_exp = 16'h00A5;
   logic        flip_en = 1'b0;
   logic [3:0]  flip_step = 4'd0;
   logic        gnt = 1'b0;
   logic [3:0]  mstep;
   always_comb begin
      mstep       = bus.ba[7:4] - 4'd1;
      bus.sdrd    = model_exp[mstep] ^ (flip_en && (mstep == flip_step));
      bus.bus_gnt = gnt;
   end

   int n_asserts = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int done_cnt  = 0;

   always @(negedge clk) if (done_o === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int n);
      while (cyc < n) tick();
   endtask

   task automatic kick();
      start_i = 1'b1;
      cyc = 0;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_cyc);
      while (done_o !== 1'b1 && cyc < 200) tick();
      chk(tag, 32'(cyc), 32'(exp_cyc));
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_state"},   32'(state_o), 32'(ST_IDLE));
      chk({pfx, "_bus_req"}, 32'(bus.bus_req), 32'd0);
      chk({pfx, "_sser"},    32'(bus.sser), 32'd1);
      chk({pfx, "_br_w"},    32'(bus.br_w), 32'd1);
      chk({pfx, "_ba"},      32'(bus.ba), 32'd0);
      chk({pfx, "_busy"},    32'(busy_o), 32'd0);
      chk({pfx, "_done"},    32'(done_o), 32'd0);
      chk({pfx, "_pass"},    32'(pass_o), 32'd0);
      chk({pfx, "_aborted"}, 32'(aborted_o), 32'd0);
      chk({pfx, "_fstep"},   32'(fail_step_o), 32'd0);
   endtask

   initial begin
      // Reset
      tick();
      tick();
      chk_reset("rst");
      rst = 1'b0;
      tick();

      // Full pass with grant held high
      gnt = 1'b1;
      kick();
      chk("pass_c1_state", 32'(state_o), 32'(ST_REQ));
      chk("pass_c1_req",   32'(bus.bus_req), 32'd1);
      chk("pass_c1_sser",  32'(bus.sser), 32'd1);
      chk("pass_c1_busy",  32'(busy_o), 32'd1);
      tick();
      chk("pass_c2_state", 32'(state_o), 32'(ST_ADDR));
      chk("pass_c2_sser",  32'(bus.sser), 32'd0);
      chk("pass_c2_ba",    32'(bus.ba), 32'h1010);
      goto(4);
      chk("pass_c4_state", 32'(state_o), 32'(ST_SAMPLE));
      goto(5);
      chk("pass_c5_state", 32'(state_o), 32'(ST_GAP));
      chk("pass_c5_sser",  32'(bus.sser), 32'd1);
      chk("pass_c5_ba",    32'(bus.ba), 32'd0);
      goto(10);
      chk("pass_step2_ba", 32'(bus.ba), 32'h1030);
      wait_done("pass_done_cyc", 34);
      chk("pass_pass",    32'(pass_o), 32'd1);
      chk("pass_fstep",   32'(fail_step_o), 32'd0);
      chk("pass_aborted", 32'(aborted_o), 32'd0);
      chk("pass_req_off", 32'(bus.bus_req), 32'd0);
      tick();
      chk("pass_after_done", 32'(done_o), 32'd0);
      chk("pass_after_busy", 32'(busy_o), 32'd0);
      chk("pass_hold",       32'(pass_o), 32'd1);

      // Mismatch at step 5
      flip_en = 1'b1;
      flip_step = 4'd5;
      kick();
      goto(24);
      chk("mis_c24_state", 32'(state_o), 32'(ST_SAMPLE));
      chk("mis_c24_ba",    32'(bus.ba), 32'h1060);
      wait_done("mis_done_cyc", 25);
      chk("mis_pass",    32'(pass_o), 32'd0);
      chk("mis_fstep",   32'(fail_step_o), 32'd5);
      chk("mis_aborted", 32'(aborted_o), 32'd0);
      chk("mis_sser",    32'(bus.sser), 32'd1);
      tick();
      chk("mis_sser_after", 32'(bus.sser), 32'd1);
      chk("mis_busy_after", 32'(busy_o), 32'd0);
      flip_en = 1'b0;

      // Delayed grant: grant rises 7 cycles after bus_req
      gnt = 1'b0;
      kick();
      for (int c = 1; c <= 7; c++) begin
         goto(c);
         chk("dly_req_state", 32'(state_o), 32'(ST_REQ));
         chk("dly_req_sser",  32'(bus.sser), 32'd1);
      end
      goto(8);
      gnt = 1'b1;
      #1;
      chk("dly_gnt_sser", 32'(bus.sser), 32'd1);
      tick();
      chk("dly_addr_state", 32'(state_o), 32'(ST_ADDR));
      chk("dly_addr_sser",  32'(bus.sser), 32'd0);
      chk("dly_addr_ba",    32'(bus.ba), 32'h1010);
      wait_done("dly_done_cyc", 41);
      chk("dly_pass", 32'(pass_o), 32'd1);
      tick();

      // Grant lost in step 3 SAMPLE
      kick();
      goto(16);
      chk("gl_state", 32'(state_o), 32'(ST_SAMPLE));
      chk("gl_sser_before", 32'(bus.sser), 32'd0);
      gnt = 1'b0;
      #1;
      chk("gl_sser_forced", 32'(bus.sser), 32'd1);
      tick();
      chk("gl_done",    32'(done_o), 32'd1);
      chk("gl_aborted", 32'(aborted_o), 32'd1);
      chk("gl_fstep",   32'(fail_step_o), 32'd3);
      chk("gl_pass",    32'(pass_o), 32'd0);
      chk("gl_req",     32'(bus.bus_req), 32'd0);
      gnt = 1'b1;
      tick();
      chk("gl_idle", 32'(state_o), 32'(ST_IDLE));

      // Reset in step 4 ADDR, then a clean pass
      kick();
      goto(18);
      chk("mrst_state", 32'(state_o), 32'(ST_ADDR));
      chk("mrst_ba",    32'(bus.ba), 32'h1050);
      rst = 1'b1;
      tick();
      chk_reset("mrst");
      rst = 1'b0;
      tick();
      kick();
      wait_done("mrst_pass_cyc", 34);
      chk("mrst_pass", 32'(pass_o), 32'd1);
      tick();

      // start while busy and start coincident with done are ignored
      done_cnt = 0;
      kick();
      goto(5);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      goto(34);
      chk("ign_done_at_34", 32'(done_o), 32'd1);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("ign_state", 32'(state_o), 32'(ST_IDLE));
      chk("ign_busy",  32'(busy_o), 32'd0);
      repeat (40) tick();
      chk("ign_done_count", 32'(done_cnt), 32'd1);
      chk("ign_still_idle", 32'(state_o), 32'(ST_IDLE));

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
